ex_mem_stage: RTL and testbench

Parametrised EX/MEM pipeline register for the OpenMIPS-style five-stage core; the next generation of the fixed-width EX/MEM latch. Carries the register-file write channel, the HI/LO write channel and the multi-cycle arithmetic carry state (count plus double-width temporary) from the execute stage to the memory stage. Adds:
- a configurable stall-vector position;
- a synchronous flush;
- a valid bit;
- a saturating stall-cycle counter;
- an asynchronous active-low reset.

---
 rtl/ex_mem_stage.sv | 108 ++++++++++
 tb/tb_ex_mem_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: write channel, HI/LO channel, multi-cycle carry state and stall-cycle counter.
// Optional carry path enabled by `EXMEM_MCARRY_EN; otherwise cnt_o/hilo_temp_o are tied to 0.
module ex_mem_stage #(
   parameter int DW    = 32,
   parameter int AW    = 5,
   parameter int CNTW  = 2,
   parameter int SW    = 6,
   parameter int STAGE = 3,
   parameter int SCW   = 4
) (
   input  logic            clk,
   input  logic            Rst_n,
   input  logic [SW-1:0]   stall,
   input  logic            flush,
   input  logic            ex_valid,
   input  logic [AW-1:0]   ex_wd,
   input  logic            ex_wreg,
   input  logic [DW-1:0]   ex_wdata,
   input  logic            ex_whilo,
   input  logic [DW-1:0]   ex_hi_i,
   input  logic [DW-1:0]   ex_lo_i,
   input  logic [CNTW-1:0] cnt_i,
   input  logic [2*DW-1:0] hilo_temp_i,
   output logic            mem_valid,
   output logic [AW-1:0]   mem_wd,
   output logic            mem_wreg,
   output logic [DW-1:0]   mem_wdata,
   output logic            mem_whilo,
   output logic [DW-1:0]   mem_hi_o,
   output logic [DW-1:0]   mem_lo_o,
   output logic [CNTW-1:0] cnt_o,
   output logic [2*DW-1:0] hilo_temp_o,
   output logic [SCW-1:0]  stall_cycles
);

   localparam logic [SCW-1:0] SC_MAX = '1;

   logic s_stall;
   logic n_stall;

   assign s_stall = stall[STAGE];
   assign n_stall = stall[STAGE+1];

   // Bubble zeroes the channel; hold (downstream also stalled) keeps it.
   always_ff @(posedge clk or negedge Rst_n) begin
      if (!Rst_n || flush) begin
         mem_valid <= 1'b0;
         mem_wd    <= '0;
         mem_wreg  <= 1'b0;
         mem_wdata <= '0;
         mem_whilo <= 1'b0;
         mem_hi_o  <= '0;
         mem_lo_o  <= '0;
      end else if (!s_stall) begin
         mem_valid <= ex_valid;
         mem_wd    <= ex_wd;
         mem_wreg  <= ex_wreg;
         mem_wdata <= ex_wdata;
         mem_whilo <= ex_whilo;
         mem_hi_o  <= ex_hi_i;
         mem_lo_o  <= ex_lo_i;
      end else if (!n_stall) begin
         mem_valid <= 1'b0;
         mem_wd    <= '0;
         mem_wreg  <= 1'b0;
         mem_wdata <= '0;
         mem_whilo <= 1'b0;
         mem_hi_o  <= '0;
         mem_lo_o  <= '0;
      end
   end

   always_ff @(posedge clk or negedge Rst_n) begin
      if (!Rst_n) begin
         stall_cycles <= '0;
      end else if (flush || !s_stall) begin
         stall_cycles <= '0;
      end else if (stall_cycles != SC_MAX) begin
         stall_cycles <= stall_cycles + 1'b1;
      end
   end

`ifdef EXMEM_MCARRY_EN
   // Carry state only survives while this stage is stalled; advance or flush restarts from 0.
   always_ff @(posedge clk or negedge Rst_n) begin
      if (!Rst_n) begin
         cnt_o       <= '0;
         hilo_temp_o <= '0;
      end else if (flush || !s_stall) begin
         cnt_o       <= '0;
         hilo_temp_o <= '0;
      end else begin
         cnt_o       <= cnt_i;
         hilo_temp_o <= hilo_temp_i;
      end
   end

   logic unused_stall;
   assign unused_stall = ^stall;
`else
   assign cnt_o       = '0;
   assign hilo_temp_o = '0;

   logic unused_carry;
   assign unused_carry = ^{stall, cnt_i, hilo_temp_i};
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed table-driven bench for ex_mem_stage plus reset and saturation sequences.
module tb_ex_mem_stage;

`ifdef EXMEM_MCARRY_EN
   localparam bit CARRY = 1'b1;
`else
   localparam bit CARRY = 1'b0;
`endif

   logic        clk;
   logic        Rst_n;
   logic [5:0]  stall;
   logic        flush;
   logic        ex_valid;
   logic [4:0]  ex_wd;
   logic        ex_wreg;
   logic [31:0] ex_wdata;
   logic        ex_whilo;
   logic [31:0] ex_hi_i;
   logic [31:0] ex_lo_i;
   logic [1:0]  cnt_i;
   logic [63:0] hilo_temp_i;

   logic        mem_valid, mem_wreg, mem_whilo;
   logic [4:0]  mem_wd;
   logic [31:0] mem_wdata, mem_hi_o, mem_lo_o;
   logic [1:0]  cnt_o;
   logic [63:0] hilo_temp_o;
   logic [3:0]  stall_cycles;

   logic        s_valid, s_wreg, s_whilo;
   logic [4:0]  s_wd;
   logic [31:0] s_wdata, s_hi, s_lo;
   logic [1:0]  s_cnt;
   logic [63:0] s_hilo;
   logic [1:0]  s_sc;

   int tests = 0;
   int fails = 0;

   ex_mem_stage dut (
      .clk(clk), .Rst_n(Rst_n), .stall(stall), .flush(flush), .ex_valid(ex_valid),
      .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_whilo(ex_whilo),
      .ex_hi_i(ex_hi_i), .ex_lo_i(ex_lo_i), .cnt_i(cnt_i), .hilo_temp_i(hilo_temp_i),
      .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
      .mem_whilo(mem_whilo), .mem_hi_o(mem_hi_o), .mem_lo_o(mem_lo_o), .cnt_o(cnt_o),
      .hilo_temp_o(hilo_temp_o), .stall_cycles(stall_cycles)
   );

   ex_mem_stage #(.SCW(2)) dut_sat (
      .clk(clk), .Rst_n(Rst_n), .stall(stall), .flush(flush), .ex_valid(ex_valid),
      .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_whilo(ex_whilo),
      .ex_hi_i(ex_hi_i), .ex_lo_i(ex_lo_i), .cnt_i(cnt_i), .hilo_temp_i(hilo_temp_i),
      .mem_valid(s_valid), .mem_wd(s_wd), .mem_wreg(s_wreg), .mem_wdata(s_wdata),
      .mem_whilo(s_whilo), .mem_hi_o(s_hi), .mem_lo_o(s_lo), .cnt_o(s_cnt),
      .hilo_temp_o(s_hilo), .stall_cycles(s_sc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  stall;
      logic        flush;
      logic        valid;
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] wdata;
      logic        whilo;
      logic [31:0] hi;
      logic [31:0] lo;
      logic [1:0]  cnt;
      logic [63:0] hilo;
      logic        e_valid;
      logic [4:0]  e_wd;
      logic        e_wreg;
      logic [31:0] e_wdata;
      logic        e_whilo;
      logic [31:0] e_hi;
      logic [31:0] e_lo;
      logic [1:0]  e_cnt;
      logic [63:0] e_hilo;
      logic [3:0]  e_sc;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " valid"}, 64'(mem_valid), 64'd0);
      chk({tag, " wd"}, 64'(mem_wd), 64'd0);
      chk({tag, " wreg"}, 64'(mem_wreg), 64'd0);
      chk({tag, " wdata"}, 64'(mem_wdata), 64'd0);
      chk({tag, " whilo"}, 64'(mem_whilo), 64'd0);
      chk({tag, " hi"}, 64'(mem_hi_o), 64'd0);
      chk({tag, " lo"}, 64'(mem_lo_o), 64'd0);
      chk({tag, " cnt"}, 64'(cnt_o), 64'd0);
      chk({tag, " hilo_temp"}, hilo_temp_o, 64'd0);
      chk({tag, " stall_cycles"}, 64'(stall_cycles), 64'd0);
      chk({tag, " sat stall_cycles"}, 64'(s_sc), 64'd0);
      chk({tag, " sat wdata"}, 64'(s_wdata), 64'd0);
   endtask

   initial begin
      Rst_n = 1'b0; stall = '0; flush = 1'b0; ex_valid = 1'b0; ex_wd = '0; ex_wreg = 1'b0;
      ex_wdata = '0; ex_whilo = 1'b0; ex_hi_i = '0; ex_lo_i = '0; cnt_i = '0; hilo_temp_i = '0;

      //          stall      fl valid wd   wreg wdata         whilo hi     lo     cnt   hilo                   | e_valid e_wd e_wreg e_wdata     e_whilo e_hi  e_lo   e_cnt e_hilo                 e_sc
      vecs[0]  = '{6'b000000, 0, 1, 5'd5,  1, 32'h12345678, 1, 32'hA, 32'hB, 2'd3, 64'hFFFF,               1, 5'd5,  1, 32'h12345678, 1, 32'hA, 32'hB, 2'd0, 64'h0,                 4'd0};
      vecs[1]  = '{6'b001111, 0, 1, 5'd7,  1, 32'h99,       1, 32'hC, 32'hD, 2'd1, 64'h0000_0001_0000_0002, 0, 5'd0,  0, 32'h0,        0, 32'h0, 32'h0, 2'd1, 64'h0000_0001_0000_0002, 4'd1};
      vecs[2]  = '{6'b001111, 0, 1, 5'd7,  1, 32'h99,       1, 32'hC, 32'hD, 2'd2, 64'h0000_0001_0000_0003, 0, 5'd0,  0, 32'h0,        0, 32'h0, 32'h0, 2'd2, 64'h0000_0001_0000_0003, 4'd2};
      vecs[3]  = '{6'b000000, 0, 1, 5'd2,  1, 32'h55,       0, 32'h0, 32'h0, 2'd0, 64'h0,                  1, 5'd2,  1, 32'h55,       0, 32'h0, 32'h0, 2'd0, 64'h0,                 4'd0};
      vecs[4]  = '{6'b011111, 0, 1, 5'd9,  1, 32'h77,       1, 32'hE, 32'hF, 2'd1, 64'h10,                 1, 5'd2,  1, 32'h55,       0, 32'h0, 32'h0, 2'd1, 64'h10,                4'd1};
      vecs[5]  = '{6'b011111, 0, 1, 5'd9,  1, 32'h77,       1, 32'hE, 32'hF, 2'd2, 64'h20,                 1, 5'd2,  1, 32'h55,       0, 32'h0, 32'h0, 2'd2, 64'h20,                4'd2};
      vecs[6]  = '{6'b011111, 0, 1, 5'd9,  1, 32'h77,       1, 32'hE, 32'hF, 2'd3, 64'h30,                 1, 5'd2,  1, 32'h55,       0, 32'h0, 32'h0, 2'd3, 64'h30,                4'd3};
      vecs[7]  = '{6'b001111, 1, 1, 5'd9,  1, 32'h77,       1, 32'hE, 32'hF, 2'd3, 64'h40,                 0, 5'd0,  0, 32'h0,        0, 32'h0, 32'h0, 2'd0, 64'h0,                 4'd0};
      vecs[8]  = '{6'b010000, 0, 0, 5'd4,  0, 32'hAB,       0, 32'h0, 32'h0, 2'd2, 64'h50,                 0, 5'd4,  0, 32'hAB,       0, 32'h0, 32'h0, 2'd0, 64'h0,                 4'd0};
      vecs[9]  = '{6'b001111, 0, 1, 5'd3,  1, 32'h1,        0, 32'h0, 32'h0, 2'd1, 64'h60,                 0, 5'd0,  0, 32'h0,        0, 32'h0, 32'h0, 2'd1, 64'h60,                4'd1};
      vecs[10] = '{6'b111111, 1, 1, 5'd3,  1, 32'h1,        0, 32'h0, 32'h0, 2'd2, 64'h70,                 0, 5'd0,  0, 32'h0,        0, 32'h0, 32'h0, 2'd0, 64'h0,                 4'd0};
      vecs[11] = '{6'b000000, 0, 1, 5'd31, 1, 32'hFFFFFFFF, 1, 32'h1, 32'h2, 2'd3, 64'h80,                 1, 5'd31, 1, 32'hFFFFFFFF, 1, 32'h1, 32'h2, 2'd0, 64'h0,                 4'd0};

      #12;
      chk_all_zero("reset");
      @(negedge clk);
      Rst_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         stall = vecs[i].stall; flush = vecs[i].flush; ex_valid = vecs[i].valid;
         ex_wd = vecs[i].wd; ex_wreg = vecs[i].wreg; ex_wdata = vecs[i].wdata;
         ex_whilo = vecs[i].whilo; ex_hi_i = vecs[i].hi; ex_lo_i = vecs[i].lo;
         cnt_i = vecs[i].cnt; hilo_temp_i = vecs[i].hilo;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d valid", i), 64'(mem_valid), 64'(vecs[i].e_valid));
         chk($sformatf("v%0d wd", i), 64'(mem_wd), 64'(vecs[i].e_wd));
         chk($sformatf("v%0d wreg", i), 64'(mem_wreg), 64'(vecs[i].e_wreg));
         chk($sformatf("v%0d wdata", i), 64'(mem_wdata), 64'(vecs[i].e_wdata));
         chk($sformatf("v%0d whilo", i), 64'(mem_whilo), 64'(vecs[i].e_whilo));
         chk($sformatf("v%0d hi", i), 64'(mem_hi_o), 64'(vecs[i].e_hi));
         chk($sformatf("v%0d lo", i), 64'(mem_lo_o), 64'(vecs[i].e_lo));
         chk($sformatf("v%0d cnt", i), 64'(cnt_o), CARRY ? 64'(vecs[i].e_cnt) : 64'd0);
         chk($sformatf("v%0d hilo_temp", i), hilo_temp_o, CARRY ? vecs[i].e_hilo : 64'd0);
         chk($sformatf("v%0d stall_cycles", i), 64'(stall_cycles), 64'(vecs[i].e_sc));
      end

      // Long hold: wide counter saturates at 15, SCW=2 instance at 3.
      @(negedge clk);
      stall = 6'b011111; flush = 1'b0; cnt_i = 2'd1;
      for (int i = 1; i <= 17; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("sat4 cycle %0d", i), 64'(stall_cycles), 64'((i > 15) ? 15 : i));
         chk($sformatf("sat2 cycle %0d", i), 64'(s_sc), 64'((i > 3) ? 3 : i));
      end
      chk("hold keeps wdata", 64'(mem_wdata), 64'hFFFFFFFF);
      chk("hold keeps valid", 64'(mem_valid), 64'd1);
      @(negedge clk);
      stall = 6'b000000;
      @(posedge clk);
      #1;
      chk("sat4 clears on advance", 64'(stall_cycles), 64'd0);
      chk("sat2 clears on advance", 64'(s_sc), 64'd0);

      // Asynchronous reset mid-stream, asserted between edges.
      @(negedge clk);
      ex_valid = 1'b1; ex_wdata = 32'hDEADBEEF; ex_wreg = 1'b1; ex_wd = 5'd6;
      @(posedge clk);
      #1;
      chk("pre-reset wdata", 64'(mem_wdata), 64'hDEADBEEF);
      @(negedge clk);
      stall = 6'b001111; cnt_i = 2'd3; hilo_temp_i = 64'h1234;
      @(posedge clk);
      #2;
      Rst_n = 1'b0;
      #1;
      chk_all_zero("async reset");
      @(negedge clk);
      Rst_n = 1'b1;
      stall = 6'b000000;
      @(posedge clk);
      #1;
      chk("post-reset advance wdata", 64'(mem_wdata), 64'hDEADBEEF);
      chk("post-reset advance valid", 64'(mem_valid), 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish before 100000");
      $fatal(1, "timeout");
   end

endmodule
